// File: rtl/pixel_region_lat_buffer_pkg.sv
// Shared types and default sizes for the pixel-region latency buffer.
// Holds the cell-state encoding, which the cells and the top both use.
package pixel_region_pkg;

  typedef enum logic [1:0] {
    CELL_FREE = 2'd0,
    CELL_WAIT = 2'd1,
    CELL_TRIG = 2'd2
  } cell_state_e;

  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DEF_NPIX  = 4;
  localparam int unsigned DEF_TOT_W = 4;
  localparam int unsigned DEF_LAT_W = 9;
  localparam int unsigned DEF_ID_W  = 5;
  localparam int unsigned DEF_OVF_W = 8;

endpackage

// File: rtl/pixel_region_lat_buffer_if.sv
// Region-side bus of the latency buffer: hit write, trigger, token chain and readout.
// The master side is the pixel/column logic; the buffer itself is the slave.
interface pixel_region_lat_buffer_if #(
  parameter int unsigned DEPTH = pixel_region_pkg::DEF_DEPTH,
  parameter int unsigned NPIX  = pixel_region_pkg::DEF_NPIX,
  parameter int unsigned TOT_W = pixel_region_pkg::DEF_TOT_W,
  parameter int unsigned LAT_W = pixel_region_pkg::DEF_LAT_W,
  parameter int unsigned ID_W  = pixel_region_pkg::DEF_ID_W,
  parameter int unsigned OVF_W = pixel_region_pkg::DEF_OVF_W
);
  logic                    LE;
  logic [NPIX*TOT_W-1:0]   HitTot;
  logic                    L1;
  logic [ID_W-1:0]         L1Id;
  logic [LAT_W-1:0]        LatCnfg;
  logic                    PixOffCnfg;
  logic                    TokIn;
  logic                    TokOut;
  logic                    EnOut;
  logic                    ReadData;
  logic [NPIX*TOT_W-1:0]   RdTot;
  logic [ID_W-1:0]         RdL1Id;
  logic [DEPTH-1:0]        LeAddr;
  logic                    Full;
  logic [OVF_W-1:0]        OvfCnt;

  modport master (
    output LE, HitTot, L1, L1Id, LatCnfg, PixOffCnfg, TokIn, ReadData,
    input  TokOut, EnOut, RdTot, RdL1Id, LeAddr, Full, OvfCnt
  );

  modport slave (
    input  LE, HitTot, L1, L1Id, LatCnfg, PixOffCnfg, TokIn, ReadData,
    output TokOut, EnOut, RdTot, RdL1Id, LeAddr, Full, OvfCnt
  );
endinterface

// File: rtl/pixel_region_lat_cell.sv
// One latency-buffer cell: stores a hit, counts down its latency, and keeps the
// hit (tagged with the trigger ID) only if L1 is present in its match cycle.
module pixel_region_lat_cell
  import pixel_region_pkg::*;
#(
  parameter int unsigned TOT_BITS = DEF_NPIX * DEF_TOT_W,
  parameter int unsigned LAT_W    = DEF_LAT_W,
  parameter int unsigned ID_W     = DEF_ID_W
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                wr_en,
  input  logic [TOT_BITS-1:0] wr_tot,
  input  logic [LAT_W-1:0]    lat_cnfg,
  input  logic                l1,
  input  logic [ID_W-1:0]     l1_id,
  input  logic                pop,
  output logic                is_free,
  output logic                is_trig,
  output logic [TOT_BITS-1:0] tot,
  output logic [ID_W-1:0]     id
);

  cell_state_e         state_q, state_d;
  logic [LAT_W-1:0]    cnt_q, cnt_d;
  logic [TOT_BITS-1:0] tot_q, tot_d;
  logic [ID_W-1:0]     id_q, id_d;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= CELL_FREE;
      cnt_q   <= '0;
      tot_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tot_q   <= tot_d;
      id_q    <= id_d;
    end
  end

  // Write, match and pop only ever apply to a cell in the matching state, so a
  // cell freed this edge cannot be reallocated until the following edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tot_d   = tot_q;
    id_d    = id_q;
    case (state_q)
      CELL_FREE: begin
        if (wr_en) begin
          state_d = CELL_WAIT;
          cnt_d   = lat_cnfg;
          tot_d   = wr_tot;
        end
      end
      CELL_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (l1) begin
          state_d = CELL_TRIG;
          id_d    = l1_id;
        end else begin
          state_d = CELL_FREE;
        end
      end
      CELL_TRIG: begin
        if (pop) begin
          state_d = CELL_FREE;
        end
      end
      default: state_d = CELL_FREE;
    endcase
  end

  assign is_free = (state_q == CELL_FREE);
  assign is_trig = (state_q == CELL_TRIG);
  assign tot     = tot_q;
  assign id      = id_q;

endmodule

// File: rtl/pixel_region_lat_buffer.sv
// Pixel-region latency buffer: DEPTH aging cells, lowest-free allocation,
// lowest-triggered readout through the column token chain, saturating overflow count.
module pixel_region_lat_buffer
  import pixel_region_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned NPIX  = DEF_NPIX,
  parameter int unsigned TOT_W = DEF_TOT_W,
  parameter int unsigned LAT_W = DEF_LAT_W,
  parameter int unsigned ID_W  = DEF_ID_W,
  parameter int unsigned OVF_W = DEF_OVF_W
) (
  input  logic                       Clk,
  input  logic                       Reset,
  pixel_region_lat_buffer_if.slave   bus
);

  localparam int unsigned TOT_BITS = NPIX * TOT_W;

  logic [DEPTH-1:0]    cell_free;
  logic [DEPTH-1:0]    cell_trig;
  logic [DEPTH-1:0]    le_addr;
  logic [DEPTH-1:0]    rd_sel;
  logic [DEPTH-1:0]    wr_en;
  logic [DEPTH-1:0]    pop;
  logic [DEPTH:0]      free_seen;
  logic [DEPTH:0]      trig_seen;
  logic [TOT_BITS-1:0] cell_tot [DEPTH];
  logic [ID_W-1:0]     cell_id  [DEPTH];

  logic                full;
  logic                any_trig;
  logic                en_out;
  logic [TOT_BITS-1:0] rd_tot;
  logic [ID_W-1:0]     rd_id;
  logic [OVF_W-1:0]    ovf_q, ovf_d;

  assign free_seen[0] = 1'b0;
  assign trig_seen[0] = 1'b0;

  // Ripple priority chains: a cell is selected when it qualifies and no
  // lower-index cell already did.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
      assign free_seen[gi+1] = free_seen[gi] | cell_free[gi];
      assign trig_seen[gi+1] = trig_seen[gi] | cell_trig[gi];
      assign le_addr[gi]     = cell_free[gi] & ~free_seen[gi];
      assign rd_sel[gi]      = cell_trig[gi] & ~trig_seen[gi];
      assign wr_en[gi]       = bus.LE & le_addr[gi];
      assign pop[gi]         = bus.ReadData & en_out & rd_sel[gi];

      pixel_region_lat_cell #(
        .TOT_BITS (TOT_BITS),
        .LAT_W    (LAT_W),
        .ID_W     (ID_W)
      ) u_cell (
        .clk      (Clk),
        .srst     (Reset),
        .wr_en    (wr_en[gi]),
        .wr_tot   (bus.HitTot),
        .lat_cnfg (bus.LatCnfg),
        .l1       (bus.L1),
        .l1_id    (bus.L1Id),
        .pop      (pop[gi]),
        .is_free  (cell_free[gi]),
        .is_trig  (cell_trig[gi]),
        .tot      (cell_tot[gi]),
        .id       (cell_id[gi])
      );
    end
  endgenerate

  assign full     = ~free_seen[DEPTH];
  assign any_trig = trig_seen[DEPTH];
  assign en_out   = ~bus.TokIn & any_trig;

  // rd_sel is one-hot, so OR-ing the masked cells is a plain mux.
  always_comb begin
    rd_tot = '0;
    rd_id  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (en_out && rd_sel[i]) begin
        rd_tot = rd_tot | cell_tot[i];
        rd_id  = rd_id  | cell_id[i];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (bus.LE && full && (ovf_q != {OVF_W{1'b1}})) begin
      ovf_d = ovf_q + 1'b1;
    end
  end

  assign bus.LeAddr = le_addr;
  assign bus.Full   = full;
  assign bus.TokOut = bus.TokIn | (any_trig & ~bus.PixOffCnfg);
  assign bus.EnOut  = en_out;
  assign bus.RdTot  = rd_tot;
  assign bus.RdL1Id = rd_id;
  assign bus.OvfCnt = ovf_q;

endmodule

// File: tb/tb_pixel_region_lat_buffer.sv
// Directed bench for the pixel-region latency buffer: expected reads go into a
// scoreboard queue, a negedge monitor checks every strobed read against it.
module tb_pixel_region_lat_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NPIX  = 4;
  localparam int unsigned TOT_W = 4;
  localparam int unsigned LAT_W = 9;
  localparam int unsigned ID_W  = 5;
  localparam int unsigned OVF_W = 2;

  typedef struct {
    logic [15:0] tot;
    logic [4:0]  id;
  } exp_t;

  logic Clk;
  logic Reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  pixel_region_lat_buffer_if #(
    .DEPTH(DEPTH), .NPIX(NPIX), .TOT_W(TOT_W),
    .LAT_W(LAT_W), .ID_W(ID_W), .OVF_W(OVF_W)
  ) bus ();

  pixel_region_lat_buffer #(
    .DEPTH(DEPTH), .NPIX(NPIX), .TOT_W(TOT_W),
    .LAT_W(LAT_W), .ID_W(ID_W), .OVF_W(OVF_W)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_read(input logic [15:0] tot, input logic [4:0] id);
    exp_t e;
    e.tot = tot;
    e.id  = id;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobed read with the bus owned is one transaction.
  always @(negedge Clk) begin
    if (!Reset && bus.EnOut && bus.ReadData) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_read: got tot=%h id=%0d expected no read", bus.RdTot, bus.RdL1Id);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("read tot=%h id=%0d (want tot=%h id=%0d)", bus.RdTot, bus.RdL1Id, e.tot, e.id);
        check("read_tot", 32'(bus.RdTot), 32'(e.tot));
        check("read_id", 32'(bus.RdL1Id), 32'(e.id));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_addr [6];
    exp_addr[0] = 4'b0001; exp_addr[1] = 4'b0010; exp_addr[2] = 4'b0100;
    exp_addr[3] = 4'b1000; exp_addr[4] = 4'b0000; exp_addr[5] = 4'b0000;

    Reset = 1'b1;
    bus.LE = 1'b0; bus.HitTot = '0; bus.L1 = 1'b0; bus.L1Id = '0;
    bus.LatCnfg = 9'd4; bus.PixOffCnfg = 1'b0; bus.TokIn = 1'b0; bus.ReadData = 1'b0;
    tick(); tick();
    Reset = 1'b0;

    // Reset state
    check("rst_leaddr", 32'(bus.LeAddr), 32'h1);
    check("rst_full", 32'(bus.Full), 32'h0);
    check("rst_enout", 32'(bus.EnOut), 32'h0);
    check("rst_tokout", 32'(bus.TokOut), 32'h0);
    check("rst_rdtot", 32'(bus.RdTot), 32'h0);
    check("rst_rdid", 32'(bus.RdL1Id), 32'h0);
    check("rst_ovf", 32'(bus.OvfCnt), 32'h0);
    bus.TokIn = 1'b1; #1;
    check("rst_tok_pass", 32'(bus.TokOut), 32'h1);
    bus.TokIn = 1'b0;

    // 1: LatCnfg=4, L1 exactly at cycle 5
    bus.LE = 1'b1; bus.HitTot = 16'hA5C3; tick();
    bus.LE = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    check("t1_enout_c5", 32'(bus.EnOut), 32'h0);
    bus.L1 = 1'b1; bus.L1Id = 5'd7; tick();
    bus.L1 = 1'b0;
    check("t1_enout_c6", 32'(bus.EnOut), 32'h1);
    check("t1_rdtot_c6", 32'(bus.RdTot), 32'hA5C3);
    expect_read(16'hA5C3, 5'd7);
    bus.ReadData = 1'b1; tick();
    bus.ReadData = 1'b0;
    check("t1_enout_c7", 32'(bus.EnOut), 32'h0);
    check("t1_leaddr_c7", 32'(bus.LeAddr), 32'h1);

    // 2: L1 one cycle early and one cycle late -> missed
    bus.LE = 1'b1; bus.HitTot = 16'h1234; tick();
    bus.LE = 1'b0;
    for (int c = 1; c < 8; c++) begin
      bus.L1 = (c == 4 || c == 6);
      bus.L1Id = 5'd3;
      if (c == 5) check("t2_leaddr_c5", 32'(bus.LeAddr), 32'h2);
      if (c == 6) check("t2_leaddr_c6", 32'(bus.LeAddr), 32'h1);
      check("t2_enout", 32'(bus.EnOut), 32'h0);
      tick();
    end
    bus.L1 = 1'b0;

    // 3: fill and overflow, saturating at 3 with OVF_W=2
    bus.LatCnfg = 9'd100;
    for (int i = 0; i < 6; i++) begin
      bus.LE = 1'b1; bus.HitTot = 16'(i + 1);
      check("t3_leaddr", 32'(bus.LeAddr), 32'(exp_addr[i]));
      tick();
      if (i == 3) check("t3_full", 32'(bus.Full), 32'h1);
    end
    check("t3_ovf2", 32'(bus.OvfCnt), 32'h2);
    for (int i = 0; i < 5; i++) tick();
    bus.LE = 1'b0;
    check("t3_ovf_sat", 32'(bus.OvfCnt), 32'h3);
    Reset = 1'b1; tick(); Reset = 1'b0;
    check("t3_ovf_clr", 32'(bus.OvfCnt), 32'h0);

    // 4: two triggered cells behind the token, then ordered readout
    bus.LatCnfg = 9'd2; bus.TokIn = 1'b1;
    bus.LE = 1'b1; bus.HitTot = 16'h1111; tick();
    bus.HitTot = 16'h2222; tick();
    bus.LE = 1'b0; tick();
    bus.L1 = 1'b1; bus.L1Id = 5'd3; tick();
    bus.L1Id = 5'd4; tick();
    bus.L1 = 1'b0;
    check("t4_enout_tok", 32'(bus.EnOut), 32'h0);
    check("t4_tokout_tok", 32'(bus.TokOut), 32'h1);
    bus.PixOffCnfg = 1'b1; #1;
    check("t4_pixoff_tokin1", 32'(bus.TokOut), 32'h1);
    bus.TokIn = 1'b0; #1;
    check("t4_pixoff_tokin0", 32'(bus.TokOut), 32'h0);
    check("t4_pixoff_enout", 32'(bus.EnOut), 32'h1);
    bus.PixOffCnfg = 1'b0; #1;
    check("t4_tokout_trig", 32'(bus.TokOut), 32'h1);
    expect_read(16'h1111, 5'd3);
    bus.ReadData = 1'b1; tick();
    expect_read(16'h2222, 5'd4);
    tick();
    bus.ReadData = 1'b0;
    check("t4_enout_done", 32'(bus.EnOut), 32'h0);
    check("t4_tokout_done", 32'(bus.TokOut), 32'h0);

    // 5: LatCnfg=0, fill with triggered cells, pop and overflowing LE together
    bus.LatCnfg = 9'd0;
    bus.LE = 1'b1; bus.HitTot = 16'h00C0; tick();
    for (int i = 1; i < 4; i++) begin
      bus.L1 = 1'b1; bus.L1Id = 5'(i); bus.HitTot = 16'(16'h00C0 + i); tick();
    end
    bus.LE = 1'b0; bus.L1Id = 5'd4; tick();
    bus.L1 = 1'b0;
    check("t5_full", 32'(bus.Full), 32'h1);
    check("t5_leaddr_full", 32'(bus.LeAddr), 32'h0);
    expect_read(16'h00C0, 5'd1);
    bus.LE = 1'b1; bus.HitTot = 16'hFFFF; bus.ReadData = 1'b1; tick();
    bus.LE = 1'b0; bus.ReadData = 1'b0;
    check("t5_ovf", 32'(bus.OvfCnt), 32'h1);
    check("t5_leaddr_freed", 32'(bus.LeAddr), 32'h1);
    check("t5_full_freed", 32'(bus.Full), 32'h0);
    for (int i = 1; i < 4; i++) expect_read(16'(16'h00C0 + i), 5'(i + 1));
    bus.ReadData = 1'b1; tick(); tick(); tick();
    bus.ReadData = 1'b0;
    check("t5_enout_drained", 32'(bus.EnOut), 32'h0);

    // 6: reset with cells in WAIT and TRIG
    bus.LatCnfg = 9'd3;
    bus.LE = 1'b1; bus.HitTot = 16'h0ABC; tick();
    bus.HitTot = 16'h0DEF; tick();
    bus.LE = 1'b0; tick(); tick();
    bus.L1 = 1'b1; bus.L1Id = 5'd9; tick();
    bus.L1 = 1'b0;
    check("t6_enout_pre", 32'(bus.EnOut), 32'h1);
    check("t6_ovf_pre", 32'(bus.OvfCnt), 32'h1);
    Reset = 1'b1; tick(); Reset = 1'b0;
    check("t6_leaddr", 32'(bus.LeAddr), 32'h1);
    check("t6_ovf", 32'(bus.OvfCnt), 32'h0);
    check("t6_enout", 32'(bus.EnOut), 32'h0);
    bus.L1 = 1'b1; bus.ReadData = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    bus.L1 = 1'b0; bus.ReadData = 1'b0;
    check("t6_enout_late", 32'(bus.EnOut), 32'h0);

    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
